// File: rtl/the_wrapper_file.sv
// AHB-Lite slave around a four-block, 128-bit-key rotate/XOR cipher engine.
// The host loads mode, key and a 16-word input buffer. A write to the last input word starts the engine.
module the_wrapper_file (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSELx,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic [1:0]  HRESP
);
    localparam int unsigned DW     = 32;
    localparam int unsigned BW     = 128;
    localparam int unsigned NWORDS = 16;
    localparam int unsigned NKEY   = 4;
    localparam int unsigned ROT    = 8;

    localparam logic [5:0] IDX_STATUS  = 6'd0;
    localparam logic [5:0] IDX_ENC     = 6'd1;
    localparam logic [5:0] IDX_DEC     = 6'd2;
    localparam logic [5:0] IDX_LAST_IN = 6'd31;

    typedef enum logic {ENG_IDLE, ENG_RUN} eng_state_t;

    eng_state_t    state_q;
    logic [DW-1:0] key_q [NKEY];
    logic [DW-1:0] in_q  [NWORDS];
    logic [DW-1:0] out_q [NWORDS];
    logic          mode_q;
    logic          busy_q;
    logic          done_q;
    logic [1:0]    blk_q;
    logic          wr_pend_q;
    logic [5:0]    wr_idx_q;

    logic          addr_valid_c;
    logic [5:0]    addr_idx_c;
    logic [DW-1:0] rd_data_c;
    logic [BW-1:0] key_c;
    logic [BW-1:0] blk_in_c;
    logic [BW-1:0] mix_c;
    logic [BW-1:0] blk_out_c;
    logic          unused_c;

    assign HREADY       = 1'b1;
    assign HRESP        = 2'b00;
    assign addr_valid_c = HSELx & HTRANS[1];
    assign addr_idx_c   = HADDR[7:2];
    assign unused_c     = ^{HBURST, HPROT, HSIZE, HADDR[31:8], HADDR[1:0], HTRANS[0]};

    // Register read mux, indexed by word address
    always_comb begin
        rd_data_c = '0;
        if (addr_idx_c == IDX_STATUS)
            rd_data_c = {29'd0, mode_q, done_q, busy_q};
        else if (addr_idx_c[5:2] == 4'd1)
            rd_data_c = key_q[addr_idx_c[1:0]];
        else if (addr_idx_c[5:4] == 2'd1)
            rd_data_c = in_q[addr_idx_c[3:0]];
        else if (addr_idx_c[5:4] == 2'd2)
            rd_data_c = out_q[addr_idx_c[3:0]];
    end

    // Buffers are write-protected while busy, so the engine reads them live instead of from a snapshot
    always_comb begin
        key_c     = {key_q[0], key_q[1], key_q[2], key_q[3]};
        blk_in_c  = {in_q[{blk_q, 2'd0}], in_q[{blk_q, 2'd1}],
                     in_q[{blk_q, 2'd2}], in_q[{blk_q, 2'd3}]};
        mix_c     = '0;
        blk_out_c = '0;
        if (mode_q) begin
            mix_c     = {blk_in_c[ROT-1:0], blk_in_c[BW-1:ROT]};
            blk_out_c = mix_c ^ key_c;
        end else begin
            mix_c     = blk_in_c ^ key_c;
            blk_out_c = {mix_c[BW-ROT-1:0], mix_c[BW-1:BW-ROT]};
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= ENG_IDLE;
            mode_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            blk_q     <= 2'd0;
            wr_pend_q <= 1'b0;
            wr_idx_q  <= 6'd0;
            HRDATA    <= '0;
            for (int i = 0; i < int'(NKEY); i++) key_q[i] <= '0;
            for (int i = 0; i < int'(NWORDS); i++) begin
                in_q[i]  <= '0;
                out_q[i] <= '0;
            end
        end else begin
            wr_pend_q <= addr_valid_c & HWRITE;
            if (addr_valid_c) wr_idx_q <= addr_idx_c;
            if (addr_valid_c && !HWRITE) HRDATA <= rd_data_c;

            // Write data phase; configuration is frozen during a run
            if (wr_pend_q && state_q == ENG_IDLE) begin
                if (wr_idx_q == IDX_ENC) mode_q <= 1'b0;
                if (wr_idx_q == IDX_DEC) mode_q <= 1'b1;
                if (wr_idx_q[5:2] == 4'd1) key_q[wr_idx_q[1:0]] <= HWDATA;
                if (wr_idx_q[5:4] == 2'd1) in_q[wr_idx_q[3:0]]  <= HWDATA;
            end

            case (state_q)
                ENG_IDLE: begin
                    if (wr_pend_q && wr_idx_q == IDX_LAST_IN) begin
                        state_q <= ENG_RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        blk_q   <= 2'd0;
                    end
                end
                ENG_RUN: begin
                    for (int j = 0; j < 4; j++)
                        out_q[{blk_q, 2'(j)}] <= blk_out_c[BW-1-DW*j -: DW];
                    blk_q <= blk_q + 2'd1;
                    if (blk_q == 2'd3) begin
                        state_q <= ENG_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ENG_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_the_wrapper_file.sv
// Directed and randomized bench for the_wrapper_file against an arithmetic cipher model.
module tb_the_wrapper_file;
    logic        tb_HCLK = 1'b0;
    logic        tb_HRESETn;
    logic        tb_HSELx;
    logic [31:0] tb_HADDR;
    logic [31:0] tb_HWDATA;
    logic [2:0]  tb_HBURST;
    logic [3:0]  tb_HPROT;
    logic [2:0]  tb_HSIZE;
    logic [1:0]  tb_HTRANS;
    logic        tb_HWRITE;
    logic [31:0] tb_HRDATA;
    logic        tb_HREADY;
    logic [1:0]  tb_HRESP;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] m_key [4];
    logic [31:0] m_in  [16];
    logic [31:0] m_out [16];
    logic        m_mode;
    logic [31:0] wbuf  [16];
    logic [31:0] rbuf  [16];

    always #5 tb_HCLK = ~tb_HCLK;

    the_wrapper_file dut (
        .HCLK    (tb_HCLK),
        .HRESETn (tb_HRESETn),
        .HSELx   (tb_HSELx),
        .HADDR   (tb_HADDR),
        .HWDATA  (tb_HWDATA),
        .HBURST  (tb_HBURST),
        .HPROT   (tb_HPROT),
        .HSIZE   (tb_HSIZE),
        .HTRANS  (tb_HTRANS),
        .HWRITE  (tb_HWRITE),
        .HRDATA  (tb_HRDATA),
        .HREADY  (tb_HREADY),
        .HRESP   (tb_HRESP)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [127:0] enc(input logic [127:0] p, input logic [127:0] k);
        logic [127:0] x;
        x = p ^ k;
        return (x << 8) | (x >> 120);
    endfunction

    function automatic logic [127:0] dec(input logic [127:0] c, input logic [127:0] k);
        return ((c >> 8) | (c << 120)) ^ k;
    endfunction

    task automatic model_run();
        logic [127:0] p, k, r;
        k = {m_key[0], m_key[1], m_key[2], m_key[3]};
        for (int b = 0; b < 4; b++) begin
            p = {m_in[4*b], m_in[4*b+1], m_in[4*b+2], m_in[4*b+3]};
            r = m_mode ? dec(p, k) : enc(p, k);
            for (int j = 0; j < 4; j++) m_out[4*b+j] = r[127-32*j -: 32];
        end
    endtask

    task automatic model_reset();
        m_mode = 1'b0;
        for (int i = 0; i < 4; i++) m_key[i] = '0;
        for (int i = 0; i < 16; i++) begin
            m_in[i]  = '0;
            m_out[i] = '0;
        end
    endtask

    task automatic bus_idle();
        tb_HSELx  = 1'b0;
        tb_HTRANS = 2'd0;
        tb_HWRITE = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        tb_HSELx = 1'b1; tb_HTRANS = 2'd2; tb_HWRITE = 1'b1; tb_HADDR = {24'h0, a};
        @(posedge tb_HCLK); #1;
        bus_idle();
        tb_HWDATA = d;
        @(posedge tb_HCLK); #1;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        tb_HSELx = 1'b1; tb_HTRANS = 2'd2; tb_HWRITE = 1'b0; tb_HADDR = {24'h0, a};
        @(posedge tb_HCLK); #1;
        d = tb_HRDATA;
        bus_idle();
    endtask

    // Pipelined INCR write burst of wbuf[0..n-1]
    task automatic wr_burst(input logic [7:0] base, input int n);
        tb_HBURST = 3'd1;
        for (int i = 0; i < n; i++) begin
            tb_HSELx = 1'b1; tb_HWRITE = 1'b1;
            tb_HTRANS = (i == 0) ? 2'd2 : 2'd3;
            tb_HADDR = {24'h0, base} + 32'(4 * i);
            if (i > 0) tb_HWDATA = wbuf[i-1];
            @(posedge tb_HCLK); #1;
        end
        bus_idle();
        tb_HWDATA = wbuf[n-1];
        @(posedge tb_HCLK); #1;
        tb_HBURST = 3'd0;
    endtask

    // Pipelined INCR read burst into rbuf[0..n-1]
    task automatic rd_burst(input logic [7:0] base, input int n);
        tb_HBURST = 3'd1;
        for (int i = 0; i < n; i++) begin
            tb_HSELx = 1'b1; tb_HWRITE = 1'b0;
            tb_HTRANS = (i == 0) ? 2'd2 : 2'd3;
            tb_HADDR = {24'h0, base} + 32'(4 * i);
            @(posedge tb_HCLK); #1;
            rbuf[i] = tb_HRDATA;
        end
        bus_idle();
        tb_HBURST = 3'd0;
    endtask

    task automatic load_key();
        wr_burst(8'h10, 4);
        for (int i = 0; i < 4; i++) m_key[i] = wbuf[i];
    endtask

    task automatic load_input_and_run();
        wr_burst(8'h40, 16);
        for (int i = 0; i < 16; i++) m_in[i] = wbuf[i];
        model_run();
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] s;
        int k;
        k = 0;
        do begin
            rd(8'h00, s);
            k++;
        end while (s[0] && k < 20);
        check(tag, s, m_mode ? 32'h6 : 32'h2);
    endtask

    task automatic check_outputs(input string tag);
        rd_burst(8'h80, 16);
        for (int i = 0; i < 16; i++) check($sformatf("%s_out%0d", tag, i), rbuf[i], m_out[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] key_ascii [4];
        logic [31:0] txt_ascii [4];
        logic [31:0] pt_words  [4];
        logic [31:0] ct_words  [4];
        key_ascii = '{32'h5A584356, 32'h424E4D41, 32'h53444647, 32'h484A4B4C};
        txt_ascii = '{32'h31323334, 32'h35363738, 32'h39303132, 32'h33343536};
        pt_words  = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
        ct_words  = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};

        tb_HRESETn = 1'b0;
        tb_HADDR = '0; tb_HWDATA = '0; tb_HBURST = '0; tb_HPROT = 4'h3; tb_HSIZE = 3'd2;
        bus_idle();
        model_reset();
        repeat (3) @(posedge tb_HCLK);
        #1;
        check("rst_hready", 32'(tb_HREADY), 32'h1);
        check("rst_hresp",  32'(tb_HRESP),  32'h0);
        check("rst_hrdata", tb_HRDATA,      32'h0);
        tb_HRESETn = 1'b1;
        @(posedge tb_HCLK); #1;
        rd(8'h00, d); check("rst_status", d, 32'h0);
        rd(8'h10, d); check("rst_key0",   d, 32'h0);
        rd(8'h80, d); check("rst_out0",   d, 32'h0);

        // Key burst and read-back
        for (int i = 0; i < 4; i++) wbuf[i] = key_ascii[i];
        load_key();
        rd_burst(8'h10, 4);
        for (int i = 0; i < 4; i++) check($sformatf("key_rb%0d", i), rbuf[i], key_ascii[i]);
        rd(8'h00, d); check("key_status", d, 32'h0);
        rd(8'h04, d); check("unmapped_04", d, 32'h0);
        rd(8'hC0, d); check("unmapped_c0", d, 32'h0);

        // Zero key, encrypt known pattern, busy exactly four status polls
        for (int i = 0; i < 4; i++) wbuf[i] = '0;
        load_key();
        wr(8'h04, 32'h0); m_mode = 1'b0;
        for (int i = 0; i < 16; i++) wbuf[i] = pt_words[i % 4];
        load_input_and_run();
        for (int i = 0; i < 5; i++) begin
            rd(8'h00, d);
            check($sformatf("busy_poll%0d", i), d, (i < 4) ? 32'h1 : 32'h2);
        end
        check_outputs("enc0");
        for (int i = 0; i < 16; i++) check($sformatf("enc0_const%0d", i), rbuf[i], ct_words[i % 4]);

        // Decrypt the previous outputs back to plaintext
        wr(8'h08, 32'h0); m_mode = 1'b1;
        for (int i = 0; i < 16; i++) wbuf[i] = rbuf[i];
        load_input_and_run();
        wait_done("dec0_status");
        check_outputs("dec0");
        for (int i = 0; i < 16; i++) check($sformatf("dec0_const%0d", i), rbuf[i], pt_words[i % 4]);

        // ASCII key and text, encrypt then decrypt round trip
        for (int i = 0; i < 4; i++) wbuf[i] = key_ascii[i];
        load_key();
        wr(8'h04, 32'h0); m_mode = 1'b0;
        for (int i = 0; i < 16; i++) wbuf[i] = txt_ascii[i % 4];
        load_input_and_run();
        wait_done("asc_enc_status");
        check_outputs("asc_enc");
        wr(8'h08, 32'h0); m_mode = 1'b1;
        for (int i = 0; i < 16; i++) wbuf[i] = rbuf[i];
        load_input_and_run();
        wait_done("asc_dec_status");
        rd_burst(8'h80, 16);
        for (int i = 0; i < 16; i++) check($sformatf("asc_rt%0d", i), rbuf[i], txt_ascii[i % 4]);

        // Randomized runs
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
            load_key();
            if ($urandom_range(0, 1) == 1) begin
                wr(8'h08, $urandom); m_mode = 1'b1;
            end else begin
                wr(8'h04, $urandom); m_mode = 1'b0;
            end
            for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
            load_input_and_run();
            wait_done($sformatf("rnd%0d_status", it));
            check_outputs($sformatf("rnd%0d", it));
        end

        // Unselected and BUSY transfers are ignored
        tb_HSELx = 1'b0; tb_HTRANS = 2'd2; tb_HWRITE = 1'b1; tb_HADDR = 32'h10;
        @(posedge tb_HCLK); #1;
        bus_idle(); tb_HWDATA = 32'hFFFF_FFFF;
        @(posedge tb_HCLK); #1;
        tb_HSELx = 1'b1; tb_HTRANS = 2'd1; tb_HWRITE = 1'b1; tb_HADDR = 32'h14;
        @(posedge tb_HCLK); #1;
        bus_idle(); tb_HWDATA = 32'hFFFF_FFFF;
        @(posedge tb_HCLK); #1;
        rd(8'h10, d); check("nosel_key0", d, m_key[0]);
        rd(8'h14, d); check("busy_key1",  d, m_key[1]);

        // Writes during a run are ignored
        for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
        load_input_and_run();
        wr(8'h10, 32'hDEAD_BEEF);
        wr(8'h40, 32'hCAFE_F00D);
        wait_done("lock_status");
        rd(8'h10, d); check("lock_key0", d, m_key[0]);
        rd(8'h40, d); check("lock_in0",  d, m_in[0]);
        check_outputs("lock");

        // Reset in the middle of a run, after block 1
        wr(8'h04, 32'h0); m_mode = 1'b0;
        for (int i = 0; i < 16; i++) wbuf[i] = $urandom | 32'h1;
        load_input_and_run();
        @(posedge tb_HCLK); @(posedge tb_HCLK); #1;
        tb_HRESETn = 1'b0;
        #1;
        check("midrst_hrdata", tb_HRDATA, 32'h0);
        @(posedge tb_HCLK); #1;
        tb_HRESETn = 1'b1;
        model_reset();
        @(posedge tb_HCLK); #1;
        rd(8'h00, d); check("midrst_status", d, 32'h0);
        rd(8'h10, d); check("midrst_key0",   d, 32'h0);
        check_outputs("midrst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
